// File: rtl/friscv_dosador_uc.sv
// Frisc-V juice dispenser control unit: N pumps, timed doses,
// pause on cup removal and abort after a cup-absence timeout.
module friscv_dosador_uc #(
    parameter int N_SUCOS       = 4,
    parameter int DOSE_CICLOS   = 1000,
    parameter int TIMEOUT_PAUSA = 500
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               liga_frisc,
    input  logic [N_SUCOS-1:0] liga_suco,
    input  logic               copo_posicionado,
    output logic [N_SUCOS-1:0] ativa_bomba,
    output logic               inicia_medida,
    output logic               pronto,
    output logic               erro,
    output logic [2:0]         db_suco,
    output logic [3:0]         db_estado
);

    localparam int DW = $clog2(DOSE_CICLOS) + 1;
    localparam int PW = $clog2(TIMEOUT_PAUSA) + 1;

    localparam logic [DW-1:0] DOSE_ULT  = DW'(DOSE_CICLOS - 1);
    localparam logic [DW-1:0] DOSE_MAX  = DW'(DOSE_CICLOS);
    localparam logic [PW-1:0] PAUSA_ULT = PW'(TIMEOUT_PAUSA - 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'b0000,
        ESPERA_ATIVAR = 4'b0001,
        DOSANDO       = 4'b0010,
        PAUSA         = 4'b0011,
        FINAL         = 4'b0100,
        ERRO          = 4'b1110
    } estado_t;

    estado_t       estado;
    logic [2:0]    sel;
    logic [DW-1:0] cnt_dose;
    logic [PW-1:0] cnt_pausa;
    logic [2:0]    sel_prox;
    logic          tem_botao;

    // Lowest pressed button wins.
    always_comb begin
        tem_botao = |liga_suco;
        sel_prox  = 3'd0;
        for (int i = N_SUCOS - 1; i >= 0; i--) begin
            if (liga_suco[i]) sel_prox = 3'(i);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= INICIAL;
            sel       <= 3'd0;
            cnt_dose  <= '0;
            cnt_pausa <= '0;
        end else if (!liga_frisc) begin
            estado <= INICIAL;
        end else begin
            case (estado)
                INICIAL: estado <= ESPERA_ATIVAR;
                ESPERA_ATIVAR: begin
                    if (copo_posicionado && tem_botao) begin
                        sel      <= sel_prox;
                        cnt_dose <= '0;
                        estado   <= DOSANDO;
                    end
                end
                DOSANDO: begin
                    // The cycle that sees the cup leave still pumped.
                    if (cnt_dose != DOSE_MAX) cnt_dose <= cnt_dose + 1'b1;
                    if (!copo_posicionado) begin
                        cnt_pausa <= '0;
                        estado    <= PAUSA;
                    end else if (cnt_dose >= DOSE_ULT) begin
                        estado <= FINAL;
                    end
                end
                PAUSA: begin
                    if (cnt_pausa != PAUSA_ULT) cnt_pausa <= cnt_pausa + 1'b1;
                    if (copo_posicionado) begin
                        estado <= DOSANDO;
                    end else if (cnt_pausa == PAUSA_ULT) begin
                        estado <= ERRO;
                    end
                end
                FINAL:   estado <= ESPERA_ATIVAR;
                ERRO:    estado <= ERRO;
                default: estado <= INICIAL;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N_SUCOS; i++) begin
            ativa_bomba[i] = (estado == DOSANDO) && (sel == 3'(i));
        end
    end

    assign inicia_medida = (estado != INICIAL);
    assign pronto        = (estado == FINAL);
    assign erro          = (estado == ERRO);
    assign db_suco       = sel;
    assign db_estado     = estado;

endmodule

// File: tb/tb_friscv_dosador_uc.sv
// Bench for friscv_dosador_uc: directed scenarios then random
// stimulus checked against a cycle-count reference model.
module tb_friscv_dosador_uc;

    localparam int N = 4;
    localparam int D = 8;
    localparam int T = 5;

    logic         clock;
    logic         reset;
    logic         liga_frisc;
    logic [N-1:0] liga_suco;
    logic         copo_posicionado;
    logic [N-1:0] ativa_bomba;
    logic         inicia_medida;
    logic         pronto;
    logic         erro;
    logic [2:0]   db_suco;
    logic [3:0]   db_estado;

    int errors = 0;
    int checks = 0;

    // Reference model: phase plus counts of pumped and cup-less cycles.
    int m_st;
    int m_sel;
    int m_pumped;
    int m_away;

    friscv_dosador_uc #(
        .N_SUCOS(N),
        .DOSE_CICLOS(D),
        .TIMEOUT_PAUSA(T)
    ) dut (
        .clock(clock),
        .reset(reset),
        .liga_frisc(liga_frisc),
        .liga_suco(liga_suco),
        .copo_posicionado(copo_posicionado),
        .ativa_bomba(ativa_bomba),
        .inicia_medida(inicia_medida),
        .pronto(pronto),
        .erro(erro),
        .db_suco(db_suco),
        .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_st = 0; m_sel = 0; m_pumped = 0; m_away = 0;
    endtask

    task automatic model_step();
        if (!liga_frisc) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: m_st = 1;
                1: if (copo_posicionado && liga_suco != 0) begin
                    m_sel = lowest(liga_suco);
                    m_pumped = 0;
                    m_st = 2;
                end
                2: begin
                    m_pumped++;
                    if (!copo_posicionado) begin
                        m_away = 0;
                        m_st = 3;
                    end else if (m_pumped >= D) begin
                        m_st = 4;
                    end
                end
                3: begin
                    m_away++;
                    if (copo_posicionado) m_st = 2;
                    else if (m_away >= T) m_st = 14;
                end
                4: m_st = 1;
                default: m_st = 14;
            endcase
        end
    endtask

    task automatic check_model(input string sfx);
        logic [7:0] bomba;
        bomba = (m_st == 2) ? 8'(1 << m_sel) : 8'd0;
        check({"bomba_", sfx}, 8'(ativa_bomba), bomba);
        check({"medida_", sfx}, 8'(inicia_medida), 8'(m_st != 0));
        check({"pronto_", sfx}, 8'(pronto), 8'(m_st == 4));
        check({"erro_", sfx}, 8'(erro), 8'(m_st == 14));
        check({"suco_", sfx}, 8'(db_suco), 8'(m_sel));
        check({"estado_", sfx}, 8'(db_estado), 8'(m_st));
    endtask

    task automatic tick(input string sfx);
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_model(sfx);
    endtask

    int pumps;
    int prontos;
    int offs;
    int pct;

    initial begin
        reset = 1'b0;
        liga_frisc = 1'b0;
        liga_suco = '0;
        copo_posicionado = 1'b0;
        model_reset();
        #3;
        check("rst_bomba", 8'(ativa_bomba), 8'h00);
        check("rst_estado", 8'(db_estado), 8'h00);
        check("rst_medida", 8'(inicia_medida), 8'h00);
        check("rst_suco", 8'(db_suco), 8'h00);
        @(negedge clock);
        reset = 1'b1;
        tick("idle");

        // Plain dose on pump 2; button released after start.
        liga_frisc = 1'b1;
        copo_posicionado = 1'b1;
        tick("en");
        liga_suco = 4'b0100;
        tick("plain");
        liga_suco = 4'b0000;
        pumps = 0; prontos = 0;
        for (int i = 0; i < 12; i++) begin
            if (ativa_bomba == 4'b0100) pumps++;
            if (pronto) prontos++;
            if (i == 0) check("plain_suco", 8'(db_suco), 8'd2);
            if (i < 11) tick("plain");
        end
        check("plain_pumps", 8'(pumps), 8'd8);
        check("plain_pronto", 8'(prontos), 8'd1);
        check("plain_back", 8'(db_estado), 8'h01);

        // Simultaneous buttons: lowest index.
        liga_suco = 4'b1010;
        tick("prio");
        check("prio_bomba", 8'(ativa_bomba), 8'h02);
        check("prio_suco", 8'(db_suco), 8'd1);
        liga_suco = 4'b0000;
        for (int i = 0; i < 10; i++) tick("prio");

        // Pause and resume: 3 on, 3 off, 5 on.
        liga_suco = 4'b0001;
        pumps = 0; prontos = 0; offs = 0;
        for (int i = 0; i < 3; i++) begin
            tick("pause");
            liga_suco = 4'b0000;
            if (ativa_bomba != 0) pumps++;
        end
        copo_posicionado = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("pause");
            if (ativa_bomba == 0) offs++;
        end
        copo_posicionado = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick("pause");
            if (ativa_bomba != 0) pumps++;
            if (pronto) prontos++;
        end
        check("pause_off", 8'(offs), 8'd3);
        check("pause_pumps", 8'(pumps), 8'd8);
        check("pause_pronto", 8'(prontos), 8'd1);

        // Timeout into erro, held with cup back, cleared by liga_frisc.
        liga_suco = 4'b1000;
        tick("tmo");
        liga_suco = 4'b0000;
        tick("tmo");
        copo_posicionado = 1'b0;
        for (int i = 0; i < 6; i++) tick("tmo");
        check("tmo_erro", 8'(erro), 8'd1);
        check("tmo_estado", 8'(db_estado), 8'h0e);
        check("tmo_bomba", 8'(ativa_bomba), 8'h00);
        copo_posicionado = 1'b1;
        tick("tmo");
        tick("tmo");
        check("tmo_hold", 8'(erro), 8'd1);
        liga_frisc = 1'b0;
        tick("tmo");
        check("tmo_clear", 8'(db_estado), 8'h00);

        // Guards: no cup means no dose; disable mid-dose.
        liga_frisc = 1'b1;
        copo_posicionado = 1'b0;
        tick("guard");
        liga_suco = 4'b0001;
        tick("guard");
        tick("guard");
        check("guard_nocup", 8'(ativa_bomba), 8'h00);
        copo_posicionado = 1'b1;
        tick("guard");
        check("guard_start", 8'(ativa_bomba), 8'h01);
        liga_suco = 4'b0000;
        liga_frisc = 1'b0;
        tick("guard");
        check("guard_off_bomba", 8'(ativa_bomba), 8'h00);
        check("guard_off_medida", 8'(inicia_medida), 8'h00);

        // Asynchronous reset mid-dose.
        liga_frisc = 1'b1;
        tick("arst");
        liga_suco = 4'b0010;
        tick("arst");
        liga_suco = 4'b0000;
        tick("arst");
        check("arst_before", 8'(ativa_bomba), 8'h02);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("arst_bomba", 8'(ativa_bomba), 8'h00);
        check("arst_estado", 8'(db_estado), 8'h00);
        check("arst_suco", 8'(db_suco), 8'h00);
        check("arst_medida", 8'(inicia_medida), 8'h00);
        liga_frisc = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick("arst_hold");
        check("arst_stay", 8'(db_estado), 8'h00);
        liga_frisc = 1'b1;
        tick("arst_go");

        // Random traffic with varying cup-absence rates.
        pct = 10;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(2))
                    0: pct = 5;
                    1: pct = 30;
                    default: pct = 75;
                endcase
            end
            liga_frisc = ($urandom_range(59) != 0);
            copo_posicionado = ($urandom_range(99) >= pct);
            liga_suco = ($urandom_range(3) == 0) ? N'($urandom) : '0;
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
